// File: rtl/fifo_mem_drain_pkg.sv
// Shared types for the fifo-to-memory drain engine.
// Holds the controller state encoding and default sizes.
package fifo_mem_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_LEN_W  = 11;

endpackage

// File: rtl/fifo_mem_drain.sv
// Drains words from a first-word-fall-through fifo into
// consecutive addresses of a single-port memory write bus.
module fifo_mem_drain
    import fifo_mem_drain_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    input  logic              fifo_empty,
    output logic              fifo_r_ready,
    input  logic [WIDTH-1:0]  fifo_data_out,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  wdone_q, wdone_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              zdone_q, zdone_d;
    logic              pop;

    // Pop when running, words remain, data present and the bus slot frees;
    // gated by reset so no word is lost on the edge that aborts a job.
    always_comb begin
        pop = reset
            & (state_q == ST_RUN)
            & (rem_q != '0)
            & ~fifo_empty
            & (~we_q | mem_ready);
    end

    // Next-state and output-register logic of the job controller.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wdone_d = wdone_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        zdone_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wdone_d = '0;
                    if (length != '0) begin
                        state_d = ST_RUN;
                        ptr_d   = base_addr;
                        rem_d   = length;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (pop) begin
                    we_d    = 1'b1;
                    wdata_d = fifo_data_out;
                    addr_d  = ptr_q;
                    ptr_d   = ptr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    wdone_d = wdone_q + 1'b1;
                end else if (we_q & mem_ready) begin
                    we_d = 1'b0;
                end
                if ((rem_q == '0) && (!we_q || mem_ready)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            wdone_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wdone_q <= wdone_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            zdone_q <= zdone_d;
        end
    end

    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE) | zdone_q;
    assign words_done   = wdone_q;
    assign fifo_r_ready = pop;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_fifo_mem_drain.sv
// Bench for fifo_mem_drain: 3-deep fifo model, 1024-word memory,
// job table plus reset, zero-length and abort sequences.
module tb_fifo_mem_drain;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] length = '0;
    logic        busy, done;
    logic [10:0] words_done;
    logic        fifo_empty, fifo_r_ready;
    logic [31:0] fifo_data_out;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    fifo_mem_drain #(.WIDTH(32), .ADDR_W(10), .LEN_W(11)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .words_done(words_done),
        .fifo_empty(fifo_empty), .fifo_r_ready(fifo_r_ready),
        .fifo_data_out(fifo_data_out),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // fifo model (depth 3) and behavioural memory
    logic [31:0] fbuf [0:2];
    int          frd = 0, fwr = 0, fcnt = 0, pops = 0, cyc = 0;
    logic        push_en = 1'b0;
    logic [31:0] push_data = '0;
    logic [31:0] mem [0:1023];
    logic [9:0]  acc_a [$];
    logic [31:0] acc_d [$];
    int          acc_c [$];

    assign fifo_empty    = (fcnt == 0);
    assign fifo_data_out = fbuf[frd];

    always @(posedge clk) begin
        if (fifo_r_ready) begin
            frd  <= (frd == 2) ? 0 : frd + 1;
            pops <= pops + 1;
        end
        if (push_en && fcnt < 3) begin
            fbuf[fwr] <= push_data;
            fwr <= (fwr == 2) ? 0 : fwr + 1;
        end
        fcnt <= fcnt + ((push_en && fcnt < 3) ? 1 : 0)
                     - (fifo_r_ready ? 1 : 0);
        if (mem_we && mem_ready) begin
            mem[mem_addr] <= mem_wdata;
            acc_a.push_back(mem_addr);
            acc_d.push_back(mem_wdata);
            acc_c.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    // words pushed but not yet consumed by a job, in push order
    logic [31:0] pend [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // protocol monitor: no pop on empty, stalled bus held, no pop while stalled
    initial begin
        logic        sp;
        logic [9:0]  pa;
        logic [31:0] pd;
        sp = 1'b0;
        pa = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (fifo_empty) begin
                    checks++;
                    if (fifo_r_ready) begin
                        errors++;
                        $display("FAIL pop_on_empty act=1 exp=0");
                    end
                end
                if (sp) begin
                    checks++;
                    if (!mem_we || mem_addr != pa || mem_wdata != pd) begin
                        errors++;
                        $display("FAIL stall_hold act=%0h/%0h exp=%0h/%0h",
                                 mem_addr, mem_wdata, pa, pd);
                    end
                end
                if (mem_we && !mem_ready) begin
                    checks++;
                    if (fifo_r_ready) begin
                        errors++;
                        $display("FAIL stall_pop act=1 exp=0");
                    end
                end
                sp = mem_we && !mem_ready;
                pa = mem_addr;
                pd = mem_wdata;
            end else begin
                sp = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic prefill(input int n);
        for (int i = 0; i < n; i++) begin
            push_en = (fcnt < 3);
            if (push_en) begin
                push_data = $urandom;
                pend.push_back(push_data);
            end
            step();
        end
        push_en = 1'b0;
        step();
    endtask

    task automatic run_job(input logic [9:0] b, input int len,
                           input int gap, input int stall, input int hold,
                           input bit restart, input logic [9:0] exp_last,
                           input int exp_span);
        int need, pushed, hcnt, bad;
        bit got, held;
        logic [9:0] ea;
        acc_a.delete();
        acc_d.delete();
        acc_c.delete();
        need = len - pend.size();
        if (need < 0) need = 0;
        pushed = 0;
        hcnt = 0;
        held = 0;
        got = 0;
        base_addr = b;
        length = 11'(len);
        start = 1'b1;
        mem_ready = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            step();
            start = 1'b0;
            if (done) begin
                got = 1;
                break;
            end
            push_en = (pushed < need) && (fcnt < 3) && (t % gap == 0);
            if (push_en) begin
                push_data = $urandom;
                pend.push_back(push_data);
                pushed++;
            end
            if (hcnt > 0) begin
                mem_ready = 1'b0;
                hcnt--;
            end else if (hold >= 0 && !held && mem_we
                         && mem_addr == hold[9:0]) begin
                mem_ready = 1'b0;
                hcnt = 2;
                held = 1;
            end else begin
                mem_ready = ($urandom_range(0, 99) >= stall);
            end
            if (restart && t == 2) begin
                start = 1'b1;
                base_addr = 10'h000;
                length = 11'd7;
            end
        end
        push_en = 1'b0;
        start = 1'b0;
        mem_ready = 1'b1;
        chk("done_seen", {63'd0, got}, 64'd1);
        chk("words_done", {53'd0, words_done}, 64'(len));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        chk("acc_count", 64'(acc_a.size()), 64'(len));
        if (acc_a.size() == len && pend.size() >= len && len > 0) begin
            bad = 0;
            for (int i = 0; i < len; i++) begin
                ea = b + 10'(i);
                if (acc_a[i] != ea || acc_d[i] != pend[i]) bad++;
                if (mem[ea] != pend[i]) bad++;
            end
            chk("order_and_mem", 64'(bad), 64'd0);
            chk("last_addr", {54'd0, acc_a[len-1]}, {54'd0, exp_last});
            chk("done_latency", 64'(cyc), 64'(acc_c[len-1] + 1));
            if (exp_span >= 0)
                chk("throughput", 64'(acc_c[len-1] - acc_c[0]),
                    64'(exp_span));
        end
        step();
        chk("done_single", {63'd0, done}, 64'd0);
        for (int i = 0; i < len && pend.size() > 0; i++)
            void'(pend.pop_front());
    endtask

    typedef struct {
        logic [9:0] base;
        int         len;
        int         pre;
        int         gap;
        int         stall;
        int         hold;
        bit         restart;
        logic [9:0] exp_last;
        int         exp_span;
    } vec_t;

    vec_t vt [8];

    initial begin
        int pops0, lost;
        vt[0] = '{10'h010, 3, 3, 1, 0, -1, 0, 10'h012, 2};
        vt[1] = '{10'h100, 5, 0, 4, 0, -1, 0, 10'h104, -1};
        vt[2] = '{10'h200, 3, 3, 1, 0, 'h201, 0, 10'h202, -1};
        vt[3] = '{10'h3FE, 4, 2, 1, 0, -1, 1, 10'h001, -1};
        for (int i = 4; i < 8; i++) begin
            vt[i].base = 10'($urandom_range(0, 1023));
            vt[i].len = $urandom_range(1, 20);
            vt[i].pre = $urandom_range(0, 3);
            vt[i].gap = $urandom_range(1, 3);
            vt[i].stall = 40;
            vt[i].hold = -1;
            vt[i].restart = 0;
            vt[i].exp_last = vt[i].base + 10'(vt[i].len - 1);
            vt[i].exp_span = -1;
        end

        reset = 1'b0;
        step();
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_pop", {63'd0, fifo_r_ready}, 64'd0);
        chk("rst_words", {53'd0, words_done}, 64'd0);
        chk("rst_addr", {54'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        reset = 1'b1;
        step();

        base_addr = 10'h055;
        length = 11'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zlen_done", {63'd0, done}, 64'd1);
        chk("zlen_busy", {63'd0, busy}, 64'd0);
        chk("zlen_words", {53'd0, words_done}, 64'd0);
        step();
        chk("zlen_done_end", {63'd0, done}, 64'd0);
        chk("zlen_busy_end", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            prefill(vt[i].pre < vt[i].len ? vt[i].pre : vt[i].len);
            run_job(vt[i].base, vt[i].len, vt[i].gap, vt[i].stall,
                    vt[i].hold, vt[i].restart, vt[i].exp_last,
                    vt[i].exp_span);
        end

        // abort a 6-word job after two accepted writes
        prefill(3);
        acc_a.delete();
        acc_d.delete();
        acc_c.delete();
        pops0 = pops;
        base_addr = 10'h300;
        length = 11'd6;
        start = 1'b1;
        for (int t = 0; t < 500; t++) begin
            step();
            start = 1'b0;
            if (acc_a.size() >= 2) break;
            push_en = (pend.size() < 6) && (fcnt < 3);
            if (push_en) begin
                push_data = $urandom;
                pend.push_back(push_data);
            end
        end
        push_en = 1'b0;
        chk("abort_reached", 64'(acc_a.size()), 64'd2);
        if (acc_a.size() >= 2) begin
            chk("abort_w0", {32'd0, acc_d[0]}, {32'd0, pend[0]});
            chk("abort_w1", {32'd0, acc_d[1]}, {32'd0, pend[1]});
        end
        reset = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_we", {63'd0, mem_we}, 64'd0);
        chk("abort_words", {53'd0, words_done}, 64'd0);
        step();
        chk("abort_done2", {63'd0, done}, 64'd0);
        chk("abort_pop", {63'd0, fifo_r_ready}, 64'd0);
        reset = 1'b1;
        mem_ready = 1'b1;
        lost = pops - pops0;
        for (int i = 0; i < lost && pend.size() > 0; i++)
            void'(pend.pop_front());
        chk("abort_fifo_left", 64'(fcnt), 64'(pend.size()));
        step();
        chk("abort_no_done", {63'd0, done}, 64'd0);
        run_job(10'h000, 4, 1, 0, -1, 0, 10'h003, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
